// File: rtl/hid_accum_ctrl_pkg.sv
// rbm_pkg: shared datapath width, saturation rails and accumulator FSM states
package rbm_pkg;
  localparam int bitlength = 12;
  localparam logic [bitlength-1:0] SAT_POS = {1'b0, {(bitlength-1){1'b1}}};
  localparam logic [bitlength-1:0] SAT_NEG = {1'b1, {(bitlength-2){1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/hid_accum_ctrl_if.sv
// hid_accum_ctrl_if: control (start/abort/bias), term stream in (valid/ready) and sum stream out (valid/ready) plus busy
interface hid_accum_ctrl_if #(parameter int W = 12);
  logic         start;
  logic         abort;
  logic [W-1:0] bias;
  logic         term_valid;
  logic [W-1:0] term_data;
  logic         term_mask;
  logic         term_ready;
  logic         sum_valid;
  logic [W-1:0] sum_data;
  logic         sum_sat;
  logic         sum_ready;
  logic         busy;
  modport master (
    output start, abort, bias, term_valid, term_data, term_mask, sum_ready,
    input  term_ready, sum_valid, sum_data, sum_sat, busy
  );
  modport slave (
    input  start, abort, bias, term_valid, term_data, term_mask, sum_ready,
    output term_ready, sum_valid, sum_data, sum_sat, busy
  );
endinterface

// File: rtl/hid_accum_ctrl_ap_adder.sv
// ap_adder: combinational symmetric saturating add (a, b -> y, ovf); rails are +/-(2^(W-1)-1), most-negative code never emitted
module ap_adder
  import rbm_pkg::*;
#(
  parameter int W = bitlength
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  localparam logic [W-1:0] POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  logic [W-1:0] tmp;
  always_comb begin
    tmp = a + b;
    ovf = (a[W-1] == b[W-1]) && (tmp[W-1] != a[W-1]);
    y   = ovf ? (a[W-1] ? NEG : POS) : (tmp == MIN ? NEG : tmp);
  end
endmodule

// File: rtl/hid_accum_ctrl.sv
// hid_accum_ctrl: hidden-unit pre-activation sequencer (clk, rst_n, bus: start/abort/bias, term valid/ready in, sum valid/ready out, busy)
module hid_accum_ctrl
  import rbm_pkg::*;
#(
  parameter int W    = bitlength,
  parameter int NVIS = 16,
  parameter int CNTW = $clog2(NVIS + 1)
) (
  input logic             clk,
  input logic             rst_n,
  hid_accum_ctrl_if.slave bus
);
  localparam logic [CNTW-1:0] LAST = CNTW'(NVIS - 1);
  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d, term_g, add_y;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            sat_q, sat_d, add_ovf, accept, load;
  assign term_g         = bus.term_mask ? bus.term_data : '0;
  assign bus.term_ready = state_q == ACC && !bus.abort;
  assign bus.sum_valid  = state_q == DONE;
  assign bus.sum_data   = acc_q;
  assign bus.sum_sat    = sat_q;
  assign bus.busy       = state_q != IDLE;
  ap_adder #(.W(W)) u_add (
    .a  (acc_q),
    .b  (term_g),
    .y  (add_y),
    .ovf(add_ovf)
  );
  always_comb begin
    accept  = bus.term_valid && bus.term_ready;
    load    = bus.start && !bus.abort && (state_q == IDLE || (state_q == DONE && bus.sum_ready));
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (load) begin
      state_d = ACC;
      acc_d   = bus.bias;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      acc_d   = add_y;
      sat_d   = sat_q | add_ovf;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == LAST ? DONE : ACC;
    end else if (state_q == DONE && bus.sum_ready) begin
      state_d = IDLE;
    end
    if (bus.abort) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end
endmodule

// File: tb/tb_hid_accum_ctrl.sv
// tb_hid_accum_ctrl: directed-vector bench for hid_accum_ctrl with W=12, NVIS=4
module tb_hid_accum_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  hid_accum_ctrl_if #(.W(12)) bus ();
  hid_accum_ctrl #(.W(12), .NVIS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  task automatic run_acc(input logic [11:0] b, input logic [11:0] t [4], input logic [3:0] m,
                         input bit gaps, output int cyc, output int acc_n);
    int i;
    bit v, rdy;
    i = 0; v = 0; rdy = 0; cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bias  = b;
    do begin
      @(negedge clk);
      cyc++;
      if (v && rdy) i++;
      bus.start = 1'b0;
      v = (i < 4) && (!gaps || $urandom_range(1, 0) == 1);
      bus.term_valid = v;
      bus.term_data  = i < 4 ? t[i] : 12'd0;
      bus.term_mask  = i < 4 ? m[i] : 1'b0;
      rdy = bus.term_ready;
    end while (!bus.sum_valid && cyc < 60);
    bus.term_valid = 1'b0;
    acc_n = i;
  endtask
  task automatic take();
    @(negedge clk);
    bus.sum_ready = 1'b1;
    @(negedge clk);
    bus.sum_ready = 1'b0;
  endtask
  task automatic test_reset();
    n_vec++;
    if ({bus.term_ready, bus.sum_valid, bus.busy, bus.sum_sat} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000", {bus.term_ready, bus.sum_valid, bus.busy, bus.sum_sat});
    end
    n_vec++;
    if (bus.sum_data !== 12'd0) begin
      n_err++;
      $display("FAIL reset_acc: got %h want 000", bus.sum_data);
    end
  endtask
  task automatic test_basic();
    int cyc, na;
    run_acc(12'd10, '{12'd1, 12'd2, 12'd3, 12'd4}, 4'b1111, 0, cyc, na);
    n_vec++;
    if (cyc !== 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", cyc); end
    n_vec++;
    if (bus.sum_data !== 12'd20) begin n_err++; $display("FAIL basic_sum: got %0d want 20", bus.sum_data); end
    n_vec++;
    if (bus.sum_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b want 0", bus.sum_sat); end
    take();
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy got %b want 0", bus.busy); end
  endtask
  task automatic test_mask();
    int cyc, na;
    run_acc(12'd10, '{12'd100, 12'd200, 12'd300, 12'd400}, 4'b0101, 0, cyc, na);
    n_vec++;
    if (bus.sum_data !== 12'd410) begin n_err++; $display("FAIL mask_sum: got %0d want 410", bus.sum_data); end
    n_vec++;
    if (bus.sum_sat !== 1'b0) begin n_err++; $display("FAIL mask_sat: got %b want 0", bus.sum_sat); end
    take();
  endtask
  task automatic test_sat_pos();
    int cyc, na;
    run_acc(12'd2000, '{12'd40, 12'd10, 12'hFFB, 12'd0}, 4'b1111, 0, cyc, na);
    n_vec++;
    if (bus.sum_data !== 12'd2042) begin n_err++; $display("FAIL satpos_sum: got %0d want 2042", bus.sum_data); end
    n_vec++;
    if (bus.sum_sat !== 1'b1) begin n_err++; $display("FAIL satpos_flag: got %b want 1", bus.sum_sat); end
    take();
  endtask
  task automatic test_sat_neg();
    int cyc, na;
    run_acc(12'h808, '{12'hFF6, 12'd0, 12'd0, 12'd0}, 4'b1111, 0, cyc, na);
    n_vec++;
    if (bus.sum_data !== 12'h801) begin n_err++; $display("FAIL satneg_sum: got %h want 801", bus.sum_data); end
    n_vec++;
    if (bus.sum_sat !== 1'b1) begin n_err++; $display("FAIL satneg_flag: got %b want 1", bus.sum_sat); end
    take();
  endtask
  task automatic test_back_to_back();
    int cyc, na;
    run_acc(12'd0, '{12'd5, 12'd6, 12'd7, 12'd8}, 4'b1111, 1, cyc, na);
    n_vec++;
    if (na !== 4) begin n_err++; $display("FAIL gaps_accepted: got %0d want 4", na); end
    for (int k = 0; k < 5; k++) begin
      bus.term_valid = 1'b1;
      bus.term_data  = 12'd9;
      bus.term_mask  = 1'b1;
      n_vec++;
      if ({bus.sum_valid, bus.term_ready} !== 2'b10) begin
        n_err++;
        $display("FAIL hold_flags[%0d]: valid,ready got %b want 10", k, {bus.sum_valid, bus.term_ready});
      end
      n_vec++;
      if (bus.sum_data !== 12'd26) begin n_err++; $display("FAIL hold_sum[%0d]: got %0d want 26", k, bus.sum_data); end
      @(negedge clk);
    end
    bus.term_valid = 1'b0;
    bus.sum_ready  = 1'b1;
    bus.start      = 1'b1;
    bus.bias       = 12'd3;
    @(negedge clk);
    bus.sum_ready = 1'b0;
    bus.start     = 1'b0;
    n_vec++;
    if ({bus.term_ready, bus.sum_valid, bus.busy} !== 3'b101) begin
      n_err++;
      $display("FAIL b2b_restart: ready,valid,busy got %b want 101", {bus.term_ready, bus.sum_valid, bus.busy});
    end
    n_vec++;
    if (bus.sum_data !== 12'd3) begin n_err++; $display("FAIL b2b_bias: got %0d want 3", bus.sum_data); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask
  task automatic test_abort();
    int cyc, na;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bias  = 12'd0;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.term_valid = 1'b1;
    bus.term_data  = 12'd1;
    bus.term_mask  = 1'b1;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    #1;
    n_vec++;
    if (bus.term_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", bus.term_ready); end
    @(negedge clk);
    bus.abort      = 1'b0;
    bus.term_valid = 1'b0;
    n_vec++;
    if ({bus.busy, bus.sum_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_idle: busy,valid got %b want 00", {bus.busy, bus.sum_valid});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.sum_valid !== 1'b0) begin n_err++; $display("FAIL abort_nosum: got %b want 0", bus.sum_valid); end
    run_acc(12'd0, '{12'd1, 12'd1, 12'd1, 12'd1}, 4'b1111, 0, cyc, na);
    n_vec++;
    if (bus.sum_data !== 12'd4 || bus.sum_valid !== 1'b1) begin
      n_err++;
      $display("FAIL restart_sum: got %0d valid %b want 4 valid 1", bus.sum_data, bus.sum_valid);
    end
    n_vec++;
    if (bus.sum_sat !== 1'b0) begin n_err++; $display("FAIL restart_sat: got %b want 0", bus.sum_sat); end
    take();
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1;
    bus.bias  = 12'd5;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.term_valid = 1'b1;
    bus.term_data  = 12'd7;
    bus.term_mask  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.term_ready, bus.sum_valid, bus.busy, bus.sum_sat} !== 4'b0 || bus.sum_data !== 12'd0) begin
      n_err++;
      $display("FAIL rst_mid: flags %b data %h want 0000 000",
               {bus.term_ready, bus.sum_valid, bus.busy, bus.sum_sat}, bus.sum_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.term_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.sum_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_after: busy,valid got %b want 00", {bus.busy, bus.sum_valid});
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.bias = '0;
    bus.term_valid = 1'b0; bus.term_data = '0; bus.term_mask = 1'b0; bus.sum_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_mask();
    test_sat_pos();
    test_sat_neg();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
